// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: one-hot FSM state encoding,
// grant encodings and the two-way round-robin pick function.
package mem_bus_arbiter_pkg;

  // One-hot state encoding (6 states, 6 bits)
  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_I_REQ  = 6'b000010,
    ST_I_RESP = 6'b000100,
    ST_D_WR   = 6'b001000,
    ST_D_RD   = 6'b010000,
    ST_D_RESP = 6'b100000
  } arb_state_e;

  // Which channel owned the most recent grant
  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_e;

  // req[0] = instruction fetch, req[1] = data. On a tie the channel that was
  // not granted last wins; a lone request always wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input grant_e last);
    logic [1:0] gnt;
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == GRANT_INST) ? 2'b10 : 2'b01;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// rr_arb2: purely combinational 2-input round-robin grant. The last-grant
// pointer is owned by the instantiating module.
module rr_arb2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  grant_e     last_grant,
  output logic [1:0] gnt
);

  // Resolve the request vector into a one-hot (or empty) grant
  always_comb begin
    gnt = rr_pick(req, last_grant);
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory request/response port between the CPU
// instruction-fetch and data channels, one transaction outstanding at a time.
// Optional build macro MEM_ARB_PERF_CNT_EN adds conflict / busy-wait counters.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction fetch channel
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_rvalid,
  input  logic                  i_rready,
  // data channel
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic                  d_wen,
  input  logic                  d_ren,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_req_ready,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_rvalid,
  input  logic                  d_rready,
  // memory side
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wen,
  output logic                  m_ren,
  input  logic                  m_req_ready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_rvalid,
  output logic                  m_rready
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]           arb_conflict_cnt,
  output logic [31:0]           arb_busy_wait_cnt
`endif
);

  arb_state_e state_reg, state_next;
  grant_e     last_grant_reg, last_grant_next;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       d_cand;
  logic       grant_inst;
  logic       grant_data;

  assign d_cand = d_wen | d_ren;
  assign req    = {d_cand, i_req_valid};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_reg),
    .gnt        (gnt)
  );

  // Grants only happen in IDLE and never while reset is held
  assign grant_inst = (state_reg == ST_IDLE) && !rst && gnt[0];
  assign grant_data = (state_reg == ST_IDLE) && !rst && gnt[1];

  // State and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= GRANT_INST;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Capture the granted request payload; requesters may change it afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      m_addr  <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
    end else if (grant_inst) begin
      m_addr  <= i_addr;
      m_wdata <= '0;
      m_wstrb <= '0;
    end else if (grant_data) begin
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
      m_wstrb <= d_wstrb;
    end
  end

  // Next-state logic, handshakes and response steering
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    i_req_ready     = 1'b0;
    d_req_ready     = 1'b0;
    m_ren           = 1'b0;
    m_wen           = 1'b0;
    m_rready        = 1'b0;
    i_rvalid        = 1'b0;
    d_rvalid        = 1'b0;
    i_rdata         = '0;
    d_rdata         = '0;
    case (state_reg)
      ST_IDLE: begin
        if (grant_inst) begin
          i_req_ready     = 1'b1;
          last_grant_next = GRANT_INST;
          state_next      = ST_I_REQ;
        end else if (grant_data) begin
          d_req_ready     = 1'b1;
          last_grant_next = GRANT_DATA;
          // a simultaneous wen & ren is treated as a store
          state_next      = d_wen ? ST_D_WR : ST_D_RD;
        end
      end
      ST_I_REQ: begin
        m_ren = 1'b1;
        if (m_req_ready) state_next = ST_I_RESP;
      end
      ST_D_RD: begin
        m_ren = 1'b1;
        if (m_req_ready) state_next = ST_D_RESP;
      end
      ST_D_WR: begin
        m_wen = 1'b1;
        if (m_req_ready) state_next = ST_IDLE;
      end
      ST_I_RESP: begin
        m_rready = i_rready;
        i_rvalid = m_rvalid;
        i_rdata  = m_rdata;
        if (m_rvalid && i_rready) state_next = ST_IDLE;
      end
      ST_D_RESP: begin
        m_rready = d_rready;
        d_rvalid = m_rvalid;
        d_rdata  = m_rdata;
        if (m_rvalid && d_rready) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_reg;
  logic [31:0] busy_wait_cnt_reg;

  // Count IDLE tie cycles and cycles where a requester waits on a busy bus
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_reg  <= '0;
      busy_wait_cnt_reg <= '0;
    end else begin
      if ((state_reg == ST_IDLE) && (&req)) begin
        conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
      end
      if ((state_reg != ST_IDLE) && (|req)) begin
        busy_wait_cnt_reg <= busy_wait_cnt_reg + 32'd1;
      end
    end
  end

  assign arb_conflict_cnt  = conflict_cnt_reg;
  assign arb_busy_wait_cnt = busy_wait_cnt_reg;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed steps plus a scoreboard of
// expected memory requests and expected responses.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] i_addr;
  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_rdata;
  logic        i_rvalid;
  logic        i_rready;
  logic [31:0] d_addr;
  logic        d_wen;
  logic        d_ren;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_req_ready;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        d_rready;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wen;
  logic        m_ren;
  logic        m_req_ready;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_rready;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] arb_conflict_cnt;
  logic [31:0] arb_busy_wait_cnt;
`endif

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_addr      (i_addr),
    .i_req_valid (i_req_valid),
    .i_req_ready (i_req_ready),
    .i_rdata     (i_rdata),
    .i_rvalid    (i_rvalid),
    .i_rready    (i_rready),
    .d_addr      (d_addr),
    .d_wen       (d_wen),
    .d_ren       (d_ren),
    .d_wdata     (d_wdata),
    .d_wstrb     (d_wstrb),
    .d_req_ready (d_req_ready),
    .d_rdata     (d_rdata),
    .d_rvalid    (d_rvalid),
    .d_rready    (d_rready),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_wen       (m_wen),
    .m_ren       (m_ren),
    .m_req_ready (m_req_ready),
    .m_rdata     (m_rdata),
    .m_rvalid    (m_rvalid),
    .m_rready    (m_rready)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .arb_conflict_cnt  (arb_conflict_cnt),
    .arb_busy_wait_cnt (arb_busy_wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct packed {
    logic        chan;   // 0 = fetch, 1 = data
    logic [31:0] data;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare memory requests and delivered responses against the scoreboard
  task automatic sb_check();
    req_t r;
    rsp_t p;
    if (!rst) begin
      if ((m_ren || m_wen) && m_req_ready) begin
        check("sb_req_expected", 64'(exp_req_q.size() != 0), 64'd1);
        if (exp_req_q.size() != 0) begin
          r = exp_req_q.pop_front();
          check("sb_m_addr", 64'(m_addr), 64'(r.addr));
          check("sb_m_wen", 64'(m_wen), 64'(r.wen));
          check("sb_m_ren", 64'(m_ren), 64'(!r.wen));
          if (r.wen) begin
            check("sb_m_wdata", 64'(m_wdata), 64'(r.wdata));
            check("sb_m_wstrb", 64'(m_wstrb), 64'(r.wstrb));
          end
          $display("req  addr=%08h wen=%0d", m_addr, m_wen);
        end
      end
      if ((i_rvalid && i_rready) || (d_rvalid && d_rready)) begin
        check("sb_rsp_expected", 64'(exp_rsp_q.size() != 0), 64'd1);
        if (exp_rsp_q.size() != 0) begin
          p = exp_rsp_q.pop_front();
          check("sb_rsp_chan", 64'(d_rvalid), 64'(p.chan));
          check("sb_rsp_data", 64'(p.chan ? d_rdata : i_rdata), 64'(p.data));
          $display("rsp  chan=%0d data=%08h", p.chan, p.chan ? d_rdata : i_rdata);
        end
      end
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    i_req_valid = 1'b0;
    d_wen       = 1'b0;
    d_ren       = 1'b0;
    m_req_ready = 1'b0;
    m_rvalid    = 1'b0;
    i_rready    = 1'b0;
    d_rready    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    next_cycle();
    next_cycle();
    exp_req_q.delete();
    exp_rsp_q.delete();
    rst = 1'b0;
  endtask

  // Lone fetch through a zero-wait memory
  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] data);
    i_addr = addr; i_req_valid = 1'b1; m_req_ready = 1'b1; i_rready = 1'b1;
    #1;
    check("fetch_grant", 64'(i_req_ready), 64'd1);
    exp_req_q.push_back('{addr: addr, wen: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    next_cycle();
    i_req_valid = 1'b0;
    #1;
    check("fetch_m_ren", 64'(m_ren), 64'd1);
    check("fetch_m_addr", 64'(m_addr), 64'(addr));
    next_cycle();
    m_rvalid = 1'b1; m_rdata = data;
    exp_rsp_q.push_back('{chan: 1'b0, data: data});
    #1;
    check("fetch_rvalid", 64'(i_rvalid), 64'd1);
    check("fetch_rdata", 64'(i_rdata), 64'(data));
    next_cycle();
    m_rvalid = 1'b0; m_req_ready = 1'b0;
    #1;
    check("fetch_after_rvalid", 64'(i_rvalid), 64'd0);
  endtask

  // Fetch and load raised together; the load is expected to win the tie
  task automatic tie_round(input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] ddata, input logic [31:0] idata);
    i_addr = ia; i_req_valid = 1'b1; d_addr = da; d_ren = 1'b1;
    m_req_ready = 1'b1; i_rready = 1'b1; d_rready = 1'b1;
    #1;
    check("tie_d_grant", 64'(d_req_ready), 64'd1);
    check("tie_i_wait", 64'(i_req_ready), 64'd0);
    exp_req_q.push_back('{addr: da, wen: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    next_cycle();
    d_ren = 1'b0;
    #1;
    check("tie_d_m_ren", 64'(m_ren), 64'd1);
    check("tie_i_blocked", 64'(i_req_ready), 64'd0);
    next_cycle();
    m_rvalid = 1'b1; m_rdata = ddata;
    exp_rsp_q.push_back('{chan: 1'b1, data: ddata});
    #1;
    check("tie_d_rvalid", 64'(d_rvalid), 64'd1);
    check("tie_i_no_grant_on_done", 64'(i_req_ready), 64'd0);
    next_cycle();
    m_rvalid = 1'b0;
    #1;
    check("tie_i_grant", 64'(i_req_ready), 64'd1);
    exp_req_q.push_back('{addr: ia, wen: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    next_cycle();
    i_req_valid = 1'b0;
    #1;
    check("tie_i_m_addr", 64'(m_addr), 64'(ia));
    next_cycle();
    m_rvalid = 1'b1; m_rdata = idata;
    exp_rsp_q.push_back('{chan: 1'b0, data: idata});
    #1;
    check("tie_i_rvalid", 64'(i_rvalid), 64'd1);
    next_cycle();
    m_rvalid = 1'b0; m_req_ready = 1'b0;
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; m_rdata = '0;
    drive_idle();
    @(posedge clk); #1;
    do_reset();
    #1;
    // reset state
    check("rst_i_req_ready", 64'(i_req_ready), 64'd0);
    check("rst_d_req_ready", 64'(d_req_ready), 64'd0);
    check("rst_m_ren", 64'(m_ren), 64'd0);
    check("rst_m_wen", 64'(m_wen), 64'd0);
    check("rst_m_addr", 64'(m_addr), 64'd0);
    check("rst_m_rready", 64'(m_rready), 64'd0);
    check("rst_i_rvalid", 64'(i_rvalid), 64'd0);

    // 1: lone fetch
    run_fetch(32'h100, 32'h0000_0013);
    next_cycle();

    // 2: tie after reset, data first
    do_reset();
    tie_round(32'h0, 32'h2000, 32'hCAFE_0001, 32'h0000_0033);
    next_cycle();

    // 3: store with memory backpressure, fetch waits
    d_addr = 32'h3000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011; d_wen = 1'b1;
    m_req_ready = 1'b0;
    #1;
    check("st_grant", 64'(d_req_ready), 64'd1);
    exp_req_q.push_back('{addr: 32'h3000, wen: 1'b1, wdata: 32'hDEAD_BEEF, wstrb: 4'b0011});
    next_cycle();
    d_wen = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
    i_addr = 32'h400; i_req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("st_m_wen_held", 64'(m_wen), 64'd1);
      check("st_m_addr", 64'(m_addr), 64'h3000);
      check("st_m_wdata", 64'(m_wdata), 64'hDEAD_BEEF);
      check("st_m_wstrb", 64'(m_wstrb), 64'h3);
      check("st_fetch_blocked", 64'(i_req_ready), 64'd0);
      next_cycle();
    end
    m_req_ready = 1'b1;
    #1;
    check("st_accept_no_grant", 64'(i_req_ready), 64'd0);
    next_cycle();
    run_fetch(32'h400, 32'h0000_0055);
    next_cycle();

    // 4: load with response backpressure
    d_addr = 32'h4000; d_ren = 1'b1; m_req_ready = 1'b1; d_rready = 1'b0;
    #1;
    check("ld_grant", 64'(d_req_ready), 64'd1);
    exp_req_q.push_back('{addr: 32'h4000, wen: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    next_cycle();
    d_ren = 1'b0;
    #1;
    check("ld_m_ren", 64'(m_ren), 64'd1);
    next_cycle();
    m_rvalid = 1'b1; m_rdata = 32'hA5A5_5A5A;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("ld_bp_m_rready", 64'(m_rready), 64'd0);
      check("ld_bp_d_rvalid", 64'(d_rvalid), 64'd1);
      next_cycle();
    end
    d_rready = 1'b1;
    exp_rsp_q.push_back('{chan: 1'b1, data: 32'hA5A5_5A5A});
    #1;
    check("ld_m_rready", 64'(m_rready), 64'd1);
    check("ld_d_rdata", 64'(d_rdata), 64'hA5A5_5A5A);
    next_cycle();
    // m_rvalid left high in IDLE: stray response must be ignored
    #1;
    check("stray_d_rvalid", 64'(d_rvalid), 64'd0);
    check("stray_i_rvalid", 64'(i_rvalid), 64'd0);
    check("stray_m_rready", 64'(m_rready), 64'd0);
    m_rvalid = 1'b0; d_rready = 1'b0;
    next_cycle();

    // 5: reset while in I_RESP
    i_addr = 32'h500; i_req_valid = 1'b1; m_req_ready = 1'b1; i_rready = 1'b1;
    #1;
    check("r5_grant", 64'(i_req_ready), 64'd1);
    exp_req_q.push_back('{addr: 32'h500, wen: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    next_cycle();
    i_req_valid = 1'b0;
    next_cycle();
    rst = 1'b1; m_req_ready = 1'b0;
    next_cycle();
    rst = 1'b0; m_rvalid = 1'b1;
    #1;
    check("r5_i_rvalid", 64'(i_rvalid), 64'd0);
    check("r5_m_rready", 64'(m_rready), 64'd0);
    check("r5_m_ren", 64'(m_ren), 64'd0);
    check("r5_m_addr", 64'(m_addr), 64'd0);
    m_rvalid = 1'b0;
    next_cycle();
    tie_round(32'h10, 32'h5000, 32'h1111_2222, 32'h3333_4444);
    next_cycle();

    // 5b: reset in D_RESP after a load restores last_grant to INST
    d_addr = 32'h600; d_ren = 1'b1; m_req_ready = 1'b1;
    #1;
    check("r5b_grant", 64'(d_req_ready), 64'd1);
    exp_req_q.push_back('{addr: 32'h600, wen: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    next_cycle();
    d_ren = 1'b0;
    next_cycle();
    rst = 1'b1; m_req_ready = 1'b0;
    next_cycle();
    rst = 1'b0;
    #1;
    check("r5b_d_rvalid", 64'(d_rvalid), 64'd0);
    tie_round(32'h20, 32'h6000, 32'h5555_6666, 32'h7777_8888);
    next_cycle();

`ifdef MEM_ARB_PERF_CNT_EN
    // 6: four ties
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tie_round(32'h40 + 32'(k), 32'h7000 + 32'(k), 32'(k), 32'(k + 10));
    end
    next_cycle();
    check("perf_conflict", 64'(arb_conflict_cnt), 64'd4);
    check("perf_busy_wait", 64'(arb_busy_wait_cnt), 64'd8);
`endif

    check("sb_req_drained", 64'(exp_req_q.size()), 64'd0);
    check("sb_rsp_drained", 64'(exp_rsp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
